// File: rtl/execute_stage_if.sv
// Bundles the per-instruction fields the execute stage consumes and the
// ALU, condition and CC results it produces.
interface execute_stage_if #(
    parameter int WIDTH = 64
);
    logic [3:0]       icode;
    logic [3:0]       ifun;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;
    logic [WIDTH-1:0] valC;
    logic             stat_ok;
    logic [WIDTH-1:0] valE;
    logic             Cnd;
    logic             zf;
    logic             sf;
    logic             of;

    modport master (
        output icode, ifun, valA, valB, valC, stat_ok,
        input  valE, Cnd, zf, sf, of
    );

    modport slave (
        input  icode, ifun, valA, valB, valC, stat_ok,
        output valE, Cnd, zf, sf, of
    );
endinterface

// File: rtl/execute_stage.sv
// SEQ Y86-64 execute stage: ALU operand selection, valE, branch/cmov condition
// and the ZF/SF/OF condition-code register written by OPq.
module execute_stage #(
    parameter int WIDTH = 64
) (
    input  logic           clk,
    input  logic           reset,
    execute_stage_if.slave bus
);
    localparam logic [WIDTH-1:0] NEG8 = ~(WIDTH'(7));
    localparam logic [WIDTH-1:0] POS8 = WIDTH'(8);

    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_val_e;
    logic [1:0]       w_fn;
    logic             w_is_opq;
    logic             w_op_bad;
    logic             w_cc_we;
    logic             w_zf_nxt;
    logic             w_sf_nxt;
    logic             w_of_nxt;
    logic             w_cnd;
    logic             w_lt;
    logic             r_zf;
    logic             r_sf;
    logic             r_of;

    assign w_is_opq = (bus.icode == 4'h6);
    assign w_op_bad = w_is_opq && (bus.ifun > 4'd3);
    assign w_fn     = w_is_opq ? bus.ifun[1:0] : 2'd0;
    assign w_cc_we  = w_is_opq && !w_op_bad && bus.stat_ok;

    always_comb begin
        w_alu_a = '0;
        case (bus.icode)
            4'h2, 4'h6:       w_alu_a = bus.valA;
            4'h3, 4'h4, 4'h5: w_alu_a = bus.valC;
            4'h8, 4'hA:       w_alu_a = NEG8;
            4'h9, 4'hB:       w_alu_a = POS8;
            default:          w_alu_a = '0;
        endcase
    end

    always_comb begin
        w_alu_b = '0;
        case (bus.icode)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: w_alu_b = bus.valB;
            default:                                  w_alu_b = '0;
        endcase
    end

    always_comb begin
        w_result = '0;
        w_of_nxt = 1'b0;
        case (w_fn)
            2'd0: begin
                w_result = w_alu_b + w_alu_a;
                w_of_nxt = (w_alu_a[WIDTH-1] == w_alu_b[WIDTH-1]) &&
                           (w_result[WIDTH-1] != w_alu_a[WIDTH-1]);
            end
            2'd1: begin
                w_result = w_alu_b - w_alu_a;
                w_of_nxt = (w_alu_a[WIDTH-1] != w_alu_b[WIDTH-1]) &&
                           (w_result[WIDTH-1] != w_alu_b[WIDTH-1]);
            end
            2'd2:    w_result = w_alu_b & w_alu_a;
            default: w_result = w_alu_b ^ w_alu_a;
        endcase
    end

    assign w_val_e  = w_op_bad ? '0 : w_result;
    assign w_zf_nxt = (w_val_e == '0);
    assign w_sf_nxt = w_val_e[WIDTH-1];

    // Conditions look only at the registered CC, never at this cycle's OPq.
    assign w_lt = r_sf ^ r_of;
    always_comb begin
        w_cnd = 1'b0;
        if (bus.icode == 4'h2 || bus.icode == 4'h7) begin
            case (bus.ifun)
                4'd0:    w_cnd = 1'b1;
                4'd1:    w_cnd = w_lt | r_zf;
                4'd2:    w_cnd = w_lt;
                4'd3:    w_cnd = r_zf;
                4'd4:    w_cnd = ~r_zf;
                4'd5:    w_cnd = ~w_lt;
                4'd6:    w_cnd = ~w_lt & ~r_zf;
                default: w_cnd = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (w_cc_we) begin
            r_zf <= w_zf_nxt;
            r_sf <= w_sf_nxt;
            r_of <= w_of_nxt;
        end
    end

    assign bus.valE = w_val_e;
    assign bus.Cnd  = w_cnd;
    assign bus.zf   = r_zf;
    assign bus.sf   = r_sf;
    assign bus.of   = r_of;
endmodule

// File: tb/tb_execute_stage.sv
// Directed vector bench for execute_stage: combinational valE/Cnd checked in
// the cycle an instruction is presented, CC checked as the pre-edge state.
module tb_execute_stage;
    localparam int WIDTH = 64;
    localparam int NV    = 28;

    typedef struct {
        logic             rst;
        logic [3:0]       icode;
        logic [3:0]       ifun;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic             ok;
        logic [WIDTH-1:0] e;
        logic             cnd;
        logic             zf;
        logic             sf;
        logic             of;
        logic             chk_cc;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t vecs[NV];

    execute_stage_if #(.WIDTH(WIDTH)) bus ();

    execute_stage #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [3:0] icode,
                                input logic [3:0] ifun, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                                input logic ok, input logic [WIDTH-1:0] e,
                                input logic cnd, input logic zf, input logic sf,
                                input logic of, input logic chk_cc);
        vec_t v;
        v.rst = rst; v.icode = icode; v.ifun = ifun;
        v.a = a; v.b = b; v.c = c; v.ok = ok;
        v.e = e; v.cnd = cnd; v.zf = zf; v.sf = sf; v.of = of;
        v.chk_cc = chk_cc;
        return v;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cc(input string name, input logic zf, input logic sf,
                            input logic of);
        check({name, ".zf"}, {63'd0, bus.zf}, {63'd0, zf});
        check({name, ".sf"}, {63'd0, bus.sf}, {63'd0, sf});
        check({name, ".of"}, {63'd0, bus.of}, {63'd0, of});
    endtask

    task automatic drive(input logic rst, input logic [3:0] icode,
                         input logic [3:0] ifun, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                         input logic ok);
        reset       = rst;
        bus.icode   = icode;
        bus.ifun    = ifun;
        bus.valA    = a;
        bus.valB    = b;
        bus.valC    = c;
        bus.stat_ok = ok;
    endtask

    localparam logic [WIDTH-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [WIDTH-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [WIDTH-1:0] MINN = 64'h8000_0000_0000_0000;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(1'b1, 4'h0, 4'h0, '0, '0, '0, 1'b1);

        //          rst icode ifun a         b         c        ok  valE      cnd zf sf of chk
        vecs[0]  = mk(1, 4'h0, 4'h0, 64'h0,   64'h0,   64'h0,   1, 64'h0,    0, 1, 0, 0, 0);
        vecs[1]  = mk(0, 4'h7, 4'h3, 64'h0,   64'h0,   64'h0,   1, 64'h0,    1, 1, 0, 0, 1);
        vecs[2]  = mk(0, 4'h6, 4'h0, 64'h1,   MAXP,    64'h0,   1, MINN,     0, 1, 0, 0, 1);
        vecs[3]  = mk(0, 4'h7, 4'h2, 64'h0,   64'h0,   64'h0,   1, 64'h0,    0, 0, 1, 1, 1);
        vecs[4]  = mk(0, 4'h7, 4'h1, 64'h0,   64'h0,   64'h0,   1, 64'h0,    0, 0, 1, 1, 1);
        vecs[5]  = mk(0, 4'h2, 4'h4, 64'h1234, 64'h999, 64'h0,  1, 64'h1234, 1, 0, 1, 1, 1);
        vecs[6]  = mk(0, 4'h6, 4'h1, 64'h5,   64'h5,   64'h0,   1, 64'h0,    0, 0, 1, 1, 1);
        vecs[7]  = mk(0, 4'h2, 4'h4, 64'hABCD, 64'h0,  64'h0,   1, 64'hABCD, 0, 1, 0, 0, 1);
        vecs[8]  = mk(0, 4'hA, 4'h0, 64'h0,   64'h100, 64'h0,   1, 64'hF8,   0, 1, 0, 0, 1);
        vecs[9]  = mk(0, 4'hB, 4'h0, 64'h0,   64'h100, 64'h0,   1, 64'h108,  0, 1, 0, 0, 1);
        vecs[10] = mk(0, 4'h5, 4'h0, 64'h0,   64'h10,  64'h20,  1, 64'h30,   0, 1, 0, 0, 1);
        vecs[11] = mk(0, 4'h3, 4'h0, 64'h0,   64'h77,  64'h55,  1, 64'h55,   0, 1, 0, 0, 1);
        vecs[12] = mk(0, 4'h6, 4'h1, 64'h6,   64'h5,   64'h0,   1, ONES,     0, 1, 0, 0, 1);
        vecs[13] = mk(0, 4'h6, 4'h3, 64'hFF,  64'hFF,  64'h0,   0, 64'h0,    0, 0, 1, 0, 1);
        vecs[14] = mk(0, 4'h7, 4'h2, 64'h0,   64'h0,   64'h0,   1, 64'h0,    1, 0, 1, 0, 1);
        vecs[15] = mk(1, 4'h6, 4'h2, ONES,    ONES,    64'h0,   1, ONES,     0, 0, 1, 0, 1);
        vecs[16] = mk(0, 4'h6, 4'h0, ONES,    ONES,    64'h0,   1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 0, 1);
        vecs[17] = mk(0, 4'h6, 4'h7, 64'h3,   64'h4,   64'h0,   1, 64'h0,    0, 0, 1, 0, 1);
        vecs[18] = mk(0, 4'h7, 4'h5, 64'h0,   64'h0,   64'h0,   1, 64'h0,    0, 0, 1, 0, 1);
        vecs[19] = mk(0, 4'h7, 4'h6, 64'h0,   64'h0,   64'h0,   1, 64'h0,    0, 0, 1, 0, 1);
        vecs[20] = mk(0, 4'h7, 4'h9, 64'h0,   64'h0,   64'h0,   1, 64'h0,    0, 0, 1, 0, 1);
        vecs[21] = mk(0, 4'h0, 4'h0, 64'h11,  64'h22,  64'h33,  1, 64'h0,    0, 0, 1, 0, 1);
        vecs[22] = mk(0, 4'h2, 4'h0, 64'h42,  64'h7,   64'h0,   1, 64'h42,   1, 0, 1, 0, 1);
        vecs[23] = mk(0, 4'h6, 4'h1, 64'h1,   MINN,    64'h0,   1, MAXP,     0, 0, 1, 0, 1);
        vecs[24] = mk(0, 4'h7, 4'h1, 64'h0,   64'h0,   64'h0,   1, 64'h0,    1, 0, 0, 1, 1);
        vecs[25] = mk(0, 4'h6, 4'h2, 64'hF0,  64'h0F,  64'h0,   1, 64'h0,    0, 0, 0, 1, 1);
        vecs[26] = mk(0, 4'h7, 4'h3, 64'h0,   64'h0,   64'h0,   1, 64'h0,    1, 1, 0, 0, 1);
        vecs[27] = mk(0, 4'h8, 4'h0, 64'h0,   64'h200, 64'h0,   1, 64'h1F8,  0, 1, 0, 0, 1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].icode, vecs[i].ifun, vecs[i].a,
                  vecs[i].b, vecs[i].c, vecs[i].ok);
            #1;
            check($sformatf("v%0d.valE", i), bus.valE, vecs[i].e);
            check($sformatf("v%0d.Cnd", i), {63'd0, bus.Cnd}, {63'd0, vecs[i].cnd});
            if (vecs[i].chk_cc)
                check_cc($sformatf("v%0d", i), vecs[i].zf, vecs[i].sf, vecs[i].of);
        end

        // Two consecutive blocked OPqs, then one that lands.
        @(negedge clk);
        drive(1'b0, 4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, '0, 1'b0);
        #1 check("seq1.valE", bus.valE, MINN);
        @(negedge clk);
        drive(1'b0, 4'h6, 4'h1, 64'h1, 64'h0, '0, 1'b0);
        #1 check_cc("seq1.frozen", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, '0, 1'b1);
        #1 check_cc("seq1.still", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'h7, 4'h5, '0, '0, '0, 1'b1);
        #1 check_cc("seq1.upd", 1'b0, 1'b1, 1'b1);
        check("seq1.jge", {63'd0, bus.Cnd}, 64'd1);

        // Reset held across two edges with OPqs presented.
        @(negedge clk);
        drive(1'b1, 4'h6, 4'h2, ONES, 64'h1, '0, 1'b1);
        @(negedge clk);
        drive(1'b1, 4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, '0, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'h7, 4'h3, '0, '0, '0, 1'b1);
        #1 check_cc("seq2.rst", 1'b1, 1'b0, 1'b0);
        check("seq2.je", {63'd0, bus.Cnd}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
